imm_decode_sequencer: RTL and testbench
=======================================

Name: imm_decode_sequencer

Overview:
- ID-stage controller for the RV32IM pipeline.
- Decodes the IF/ID instruction into the immediate-select code and drives the immediate generator's operand and select inputs.
- Captures the generated immediate, PC and register fields into a one-entry ID/EX register with valid/ready handshaking.
- Inserts load-use bubbles, honours flush, and keeps saturating bubble and flush counters.

Parameters:
- CNT_W, 16: width of the saturating BUBBLE_CNT and FLUSH_CNT counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IF_INSTR  in  32  instruction from IF/ID.
- IF_PC  in  32  PC of IF_INSTR.
- IF_VALID  in  1  IF_INSTR/IF_PC valid.
- ID_READY  out  1  stage accepts the IF/ID instruction this cycle.
- EX_READY  in  1  EX stage accepts ID/EX contents this cycle.
- FLUSH  in  1  branch/jump redirect; kills the ID and ID/EX contents.
- IMM_SEL  out  3  combinational select to the immediate generator.
- IMM_IN  out  25  combinational, equals IF_INSTR[31:7].
- IMM_OUT  in  32  combinational immediate returned by the generator.
- ID_EX_VALID  out  1  ID/EX entry valid.
- ID_EX_PC  out  32  registered PC.
- ID_EX_IMM  out  32  registered immediate.
- ID_EX_IMM_SEL  out  3  registered select.
- ID_EX_RS1, ID_EX_RS2, ID_EX_RD  out  5 each  registered register fields.
- ID_EX_MEMREAD  out  1  entry is a LOAD.
- BUBBLE_CNT  out  CNT_W  load-use bubbles inserted.
- FLUSH_CNT  out  CNT_W  flush events that killed a valid instruction.

Behaviour:
- IMM_SEL encoding: U=000, J=001, S=010, B=011, I_SIGNED=100, I_SHIFT=101, I_UNSIGNED=110, NONE=111.
- Decode on opcode IF_INSTR[6:0]:
  - 0110111 and 0010111 -> U
  - 1101111 -> J
  - 1100111 -> I_SIGNED
  - 1100011 -> B
  - 0000011 -> I_SIGNED
  - 0100011 -> S
  - 0010011: funct3 001/101 -> I_SHIFT, otherwise I_SIGNED (SLTIU sign-extends)
  - all other opcodes, including OP/M-extension 0110011 -> NONE
- I_UNSIGNED is never emitted by this decoder.
- Register use:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - Unused fields are registered as 0.
- Advance condition: adv = !ID_EX_VALID || EX_READY.
- Hazard: hz = IF_VALID && ID_EX_VALID && ID_EX_MEMREAD && ID_EX_RD!=0 && (rs1 used and equal to ID_EX_RD, or rs2 used and equal to ID_EX_RD).
- ID_READY = FLUSH || (adv && !hz).
- FSM, two states:
  - RUN: normal operation. On adv && hz: load a bubble (ID_EX_VALID<=0), increment BUBBLE_CNT, go to BUBBLE.
  - BUBBLE: the hazard has cleared because the load has left ID/EX. The instruction is accepted normally; return to RUN. If FLUSH is asserted, return to RUN.
- Latency: an instruction accepted on edge N is visible on ID_EX_* after edge N, i.e. 1 cycle.
- A load-use pair costs exactly 1 bubble.
- Hold: when !adv, every ID_EX_* register keeps its value and the instruction stays in IF/ID.
- FLUSH has highest priority:
  - next edge: ID_EX_VALID<=0, FSM<=RUN.
  - the IF/ID instruction is consumed and discarded (ID_READY=1).
  - FLUSH_CNT increments when ID_EX_VALID or IF_VALID was 1.
  - A flush takes priority over a simultaneous hazard; no bubble is counted.
- Normal load: if adv && !hz && IF_VALID, capture IF_PC, IMM_OUT, IMM_SEL, rs/rd fields and MEMREAD, and set ID_EX_VALID=1.
- Idle: if adv && !IF_VALID, set ID_EX_VALID=0.
- Counters saturate at all-ones; they do not wrap.
- Reset:
  - All ID_EX_* outputs go to 0, including ID_EX_IMM_SEL=000.
  - Both counters go to 0 and the FSM goes to RUN.
  - Reset asserted mid-stall discards the bubble state immediately.
- Combinational outputs during reset: IMM_SEL and IMM_IN follow IF_INSTR; ID_READY=1.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), IF_VALID=1, EX_READY=1, IMM_OUT=0xFFFFFFFB -> IMM_SEL=100; next cycle ID_EX_VALID=1, ID_EX_IMM=0xFFFFFFFB, ID_EX_RD=1.
- LW x5,0(x2), then ADD x6,x5,x7 -> one cycle with ID_READY=0 and ID_EX_VALID=0, BUBBLE_CNT=1; ADD reaches ID/EX the following cycle.
- LW x0,0(x2), then ADD x6,x0,x7 -> no bubble, BUBBLE_CNT stays 0.
- EX_READY=0 for 3 cycles with a valid entry -> ID_EX_* stable, ID_READY=0; the pipeline resumes on the EX_READY rise.
- FLUSH during a load-use stall -> ID_EX_VALID=0, FSM=RUN, FLUSH_CNT=1, BUBBLE_CNT unchanged.
- Opcode coverage: SLLI→101, SW→010, BEQ→011, JAL→001, LUI→000, MUL→111. Separately, CNT_W=2 with 5 bubbles -> BUBBLE_CNT=3 (saturated). Async RESET_N low mid-stream -> all registered outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_decode_sequencer_if.sv
// ----------------------------------------------------------------------------
// imm_decode_sequencer_if
//   Bundles every IF/ID, immediate-generator, ID/EX and status signal of the
//   ID-stage controller. Clock and reset stay as plain module ports.
//
//   slave  : view taken by imm_decode_sequencer (decoder/sequencer side)
//   master : view taken by the surrounding pipeline / environment
//
//   IF side       : IF_INSTR, IF_PC, IF_VALID -> ID_READY
//   EX side       : EX_READY -> ID_EX_* entry
//   Immediate gen : IMM_SEL, IMM_IN out; IMM_OUT back in (combinational loop
//                   through the external generator, no state inside)
//   Control       : FLUSH
//   Status        : BUBBLE_CNT, FLUSH_CNT (saturating, CNT_W bits)
// ----------------------------------------------------------------------------
interface imm_decode_sequencer_if #(
  parameter int CNT_W = 16
) ();

  logic [31:0]      IF_INSTR;
  logic [31:0]      IF_PC;
  logic             IF_VALID;
  logic             ID_READY;
  logic             EX_READY;
  logic             FLUSH;
  logic [2:0]       IMM_SEL;
  logic [24:0]      IMM_IN;
  logic [31:0]      IMM_OUT;
  logic             ID_EX_VALID;
  logic [31:0]      ID_EX_PC;
  logic [31:0]      ID_EX_IMM;
  logic [2:0]       ID_EX_IMM_SEL;
  logic [4:0]       ID_EX_RS1;
  logic [4:0]       ID_EX_RS2;
  logic [4:0]       ID_EX_RD;
  logic             ID_EX_MEMREAD;
  logic [CNT_W-1:0] BUBBLE_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport slave (
    input  IF_INSTR, IF_PC, IF_VALID, EX_READY, FLUSH, IMM_OUT,
    output ID_READY, IMM_SEL, IMM_IN,
    output ID_EX_VALID, ID_EX_PC, ID_EX_IMM, ID_EX_IMM_SEL,
    output ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_MEMREAD,
    output BUBBLE_CNT, FLUSH_CNT
  );

  modport master (
    output IF_INSTR, IF_PC, IF_VALID, EX_READY, FLUSH, IMM_OUT,
    input  ID_READY, IMM_SEL, IMM_IN,
    input  ID_EX_VALID, ID_EX_PC, ID_EX_IMM, ID_EX_IMM_SEL,
    input  ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_MEMREAD,
    input  BUBBLE_CNT, FLUSH_CNT
  );

endinterface

// File: rtl/imm_decode_sequencer.sv
// ----------------------------------------------------------------------------
// imm_decode_sequencer
//   ID-stage controller for an RV32IM pipeline. Decodes the IF/ID instruction
//   into an immediate-select code, feeds the external immediate generator,
//   and captures the returned immediate together with PC and register fields
//   into a one-entry ID/EX register with valid/ready handshaking. Inserts one
//   bubble per load-use hazard, honours FLUSH, and counts bubbles and flushes
//   with saturating counters.
//
// Ports
//   CLK      : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : imm_decode_sequencer_if.slave (all data/handshake signals)
// ----------------------------------------------------------------------------
module imm_decode_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  imm_decode_sequencer_if.slave  bus
);

  // Opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate-select codes (I_UNSIGNED exists in the generator but is never
  // chosen here: SLTIU compares against a sign-extended immediate)
  localparam logic [2:0] SEL_U        = 3'b000;
  localparam logic [2:0] SEL_J        = 3'b001;
  localparam logic [2:0] SEL_S        = 3'b010;
  localparam logic [2:0] SEL_B        = 3'b011;
  localparam logic [2:0] SEL_I_SIGNED = 3'b100;
  localparam logic [2:0] SEL_I_SHIFT  = 3'b101;
  localparam logic [2:0] SEL_NONE     = 3'b111;

  // FSM states
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + CNT_ONE;
    end
    return res;
  endfunction

  // Decode results
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [2:0] imm_sel_s;
  logic       rs1_used_s;
  logic       rs2_used_s;
  logic       rd_used_s;
  logic       memread_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic [4:0] rd_s;
  logic       adv_s;
  logic       hz_s;

  // ID/EX state
  logic [0:0]       state_q,      state_d;
  logic             valid_q,      valid_d;
  logic [31:0]      pc_q,         pc_d;
  logic [31:0]      imm_q,        imm_d;
  logic [2:0]       imm_sel_q,    imm_sel_d;
  logic [4:0]       rs1_q,        rs1_d;
  logic [4:0]       rs2_q,        rs2_d;
  logic [4:0]       rd_q,         rd_d;
  logic             memread_q,    memread_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  assign opcode_s = bus.IF_INSTR[6:0];
  assign funct3_s = bus.IF_INSTR[14:12];

  // Opcode decode: immediate format plus which register fields are live
  always_comb begin
    imm_sel_s  = SEL_NONE;
    rs1_used_s = 1'b0;
    rs2_used_s = 1'b0;
    rd_used_s  = 1'b0;
    memread_s  = 1'b0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        imm_sel_s = SEL_U;
        rd_used_s = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_s = SEL_J;
        rd_used_s = 1'b1;
      end
      OPC_JALR: begin
        imm_sel_s  = SEL_I_SIGNED;
        rs1_used_s = 1'b1;
        rd_used_s  = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel_s  = SEL_B;
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel_s  = SEL_I_SIGNED;
        rs1_used_s = 1'b1;
        rd_used_s  = 1'b1;
        memread_s  = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_s  = SEL_S;
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
      end
      OPC_OPIMM: begin
        // SLLI/SRLI/SRAI carry a shamt, everything else a signed immediate
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          imm_sel_s = SEL_I_SHIFT;
        end else begin
          imm_sel_s = SEL_I_SIGNED;
        end
        rs1_used_s = 1'b1;
        rd_used_s  = 1'b1;
      end
      OPC_OP: begin
        imm_sel_s  = SEL_NONE;
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
        rd_used_s  = 1'b1;
      end
      default: begin
        imm_sel_s  = SEL_NONE;
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        rd_used_s  = 1'b0;
        memread_s  = 1'b0;
      end
    endcase
  end

  // Unused register fields are zeroed so they never create false hazards
  assign rs1_s = rs1_used_s ? bus.IF_INSTR[19:15] : 5'd0;
  assign rs2_s = rs2_used_s ? bus.IF_INSTR[24:20] : 5'd0;
  assign rd_s  = rd_used_s  ? bus.IF_INSTR[11:7]  : 5'd0;

  assign adv_s = !valid_q || bus.EX_READY;

  // Load-use: the load in ID/EX writes a register this instruction reads
  assign hz_s = bus.IF_VALID && valid_q && memread_q && (rd_q != 5'd0) &&
                ((rs1_used_s && (rs1_s == rd_q)) ||
                 (rs2_used_s && (rs2_s == rd_q)));

  // On flush the IF/ID slot is drained regardless of stall conditions
  assign bus.ID_READY = bus.FLUSH || (adv_s && !hz_s);
  assign bus.IMM_SEL  = imm_sel_s;
  assign bus.IMM_IN   = bus.IF_INSTR[31:7];

  // Next-state selection: flush > bubble > load > idle > hold
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    imm_sel_d    = imm_sel_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    memread_d    = memread_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bus.FLUSH) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
      // Only flushes that actually kill an instruction are counted
      if (valid_q || bus.IF_VALID) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else if (adv_s && hz_s) begin
      valid_d      = 1'b0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
      state_d      = ST_BUBBLE;
    end else if (adv_s && bus.IF_VALID) begin
      valid_d   = 1'b1;
      pc_d      = bus.IF_PC;
      imm_d     = bus.IMM_OUT;
      imm_sel_d = imm_sel_s;
      rs1_d     = rs1_s;
      rs2_d     = rs2_s;
      rd_d      = rd_s;
      memread_d = memread_s;
      state_d   = ST_RUN;
    end else if (adv_s) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else begin
      // EX is stalled on a valid entry: everything holds
      state_d = state_q;
    end
  end

  // ID/EX register, FSM state and counters
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_RUN;
      valid_q      <= 1'b0;
      pc_q         <= 32'd0;
      imm_q        <= 32'd0;
      imm_sel_q    <= 3'b000;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      memread_q    <= 1'b0;
      bubble_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      imm_sel_q    <= imm_sel_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      memread_q    <= memread_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ID_EX_VALID   = valid_q;
  assign bus.ID_EX_PC      = pc_q;
  assign bus.ID_EX_IMM     = imm_q;
  assign bus.ID_EX_IMM_SEL = imm_sel_q;
  assign bus.ID_EX_RS1     = rs1_q;
  assign bus.ID_EX_RS2     = rs2_q;
  assign bus.ID_EX_RD      = rd_q;
  assign bus.ID_EX_MEMREAD = memread_q;
  assign bus.BUBBLE_CNT    = bubble_cnt_q;
  assign bus.FLUSH_CNT     = flush_cnt_q;

endmodule

// File: tb/tb_imm_decode_sequencer.sv
module tb_imm_decode_sequencer;

  localparam logic [31:0] I_ADDI = 32'hFFB00093; // addi x1,x0,-5
  localparam logic [31:0] I_LW5  = 32'h00012283; // lw   x5,0(x2)
  localparam logic [31:0] I_ADD5 = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_LW0  = 32'h00012003; // lw   x0,0(x2)
  localparam logic [31:0] I_ADD0 = 32'h00700333; // add  x6,x0,x7
  localparam logic [31:0] I_SLLI = 32'h00309093; // slli x1,x1,3
  localparam logic [31:0] I_SW   = 32'h0020A223; // sw   x2,4(x1)
  localparam logic [31:0] I_LWCH = 32'h0002A283; // lw   x5,0(x5)

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  imm_decode_sequencer_if #(.CNT_W(16)) bus ();
  imm_decode_sequencer_if #(.CNT_W(2))  sbus ();

  imm_decode_sequencer #(.CNT_W(16)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  imm_decode_sequencer #(.CNT_W(2)) dut_sat (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.IF_INSTR = I_ADDI;
    #2;
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0h exp 1", bus.ID_READY); end
    checks++; if (bus.IMM_SEL !== 3'b100) begin errors++; $display("FAIL rst_imm_sel: got %0h exp 4", bus.IMM_SEL); end
    checks++; if (bus.IMM_IN !== 25'h1FF6001) begin errors++; $display("FAIL rst_imm_in: got %0h exp 1ff6001", bus.IMM_IN); end
    checks++; if (bus.ID_EX_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h exp 0", bus.ID_EX_VALID); end
    checks++; if (bus.ID_EX_IMM_SEL !== 3'b000) begin errors++; $display("FAIL rst_reg_sel: got %0h exp 0", bus.ID_EX_IMM_SEL); end
    checks++; if (bus.BUBBLE_CNT !== 16'd0 || bus.FLUSH_CNT !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0h/%0h exp 0/0", bus.BUBBLE_CNT, bus.FLUSH_CNT); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    bus.IF_INSTR = I_ADDI; bus.IF_PC = 32'h100; bus.IMM_OUT = 32'hFFFFFFFB; bus.IF_VALID = 1'b1;
    #1;
    checks++; if (bus.IMM_SEL !== 3'b100) begin errors++; $display("FAIL addi_sel: got %0h exp 4", bus.IMM_SEL); end
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL addi_ready: got %0h exp 1", bus.ID_READY); end
    tick();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.ID_EX_VALID !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0h exp 1", bus.ID_EX_VALID); end
    checks++; if (bus.ID_EX_IMM !== 32'hFFFFFFFB) begin errors++; $display("FAIL addi_imm: got %0h exp fffffffb", bus.ID_EX_IMM); end
    checks++; if (bus.ID_EX_RD !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0d exp 1", bus.ID_EX_RD); end
    checks++; if (bus.ID_EX_PC !== 32'h100) begin errors++; $display("FAIL addi_pc: got %0h exp 100", bus.ID_EX_PC); end
    checks++; if (bus.ID_EX_IMM_SEL !== 3'b100 || bus.ID_EX_MEMREAD !== 1'b0) begin errors++; $display("FAIL addi_sel_mr: got %0h/%0h exp 4/0", bus.ID_EX_IMM_SEL, bus.ID_EX_MEMREAD); end
    tick();
    checks++; if (bus.ID_EX_VALID !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0h exp 0", bus.ID_EX_VALID); end
  endtask

  task automatic test_load_use();
    bus.IF_INSTR = I_LW5; bus.IF_PC = 32'h200; bus.IMM_OUT = 32'h0; bus.IF_VALID = 1'b1;
    tick();
    bus.IF_INSTR = I_ADD5; bus.IF_PC = 32'h204;
    #1;
    checks++; if (bus.ID_READY !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %0h exp 0", bus.ID_READY); end
    checks++; if (bus.ID_EX_MEMREAD !== 1'b1 || bus.ID_EX_RD !== 5'd5 || bus.ID_EX_RS1 !== 5'd2) begin errors++; $display("FAIL lu_load_fields: got mr=%0h rd=%0d rs1=%0d exp 1/5/2", bus.ID_EX_MEMREAD, bus.ID_EX_RD, bus.ID_EX_RS1); end
    tick();
    checks++; if (bus.ID_EX_VALID !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %0h exp 0", bus.ID_EX_VALID); end
    checks++; if (bus.BUBBLE_CNT !== 16'd1) begin errors++; $display("FAIL lu_bubble_cnt: got %0d exp 1", bus.BUBBLE_CNT); end
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL lu_resume_ready: got %0h exp 1", bus.ID_READY); end
    tick();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.ID_EX_VALID !== 1'b1 || bus.ID_EX_PC !== 32'h204) begin errors++; $display("FAIL lu_add_entry: got v=%0h pc=%0h exp 1/204", bus.ID_EX_VALID, bus.ID_EX_PC); end
    checks++; if (bus.ID_EX_RS1 !== 5'd5 || bus.ID_EX_RS2 !== 5'd7 || bus.ID_EX_RD !== 5'd6) begin errors++; $display("FAIL lu_add_regs: got %0d/%0d/%0d exp 5/7/6", bus.ID_EX_RS1, bus.ID_EX_RS2, bus.ID_EX_RD); end
    checks++; if (bus.ID_EX_MEMREAD !== 1'b0 || bus.ID_EX_IMM_SEL !== 3'b111) begin errors++; $display("FAIL lu_add_ctl: got mr=%0h sel=%0h exp 0/7", bus.ID_EX_MEMREAD, bus.ID_EX_IMM_SEL); end
    tick();
  endtask

  task automatic test_x0_load();
    bus.IF_INSTR = I_LW0; bus.IF_PC = 32'h300; bus.IMM_OUT = 32'h0; bus.IF_VALID = 1'b1;
    tick();
    bus.IF_INSTR = I_ADD0; bus.IF_PC = 32'h304;
    #1;
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0h exp 1", bus.ID_READY); end
    tick();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.ID_EX_VALID !== 1'b1 || bus.ID_EX_PC !== 32'h304) begin errors++; $display("FAIL x0_entry: got v=%0h pc=%0h exp 1/304", bus.ID_EX_VALID, bus.ID_EX_PC); end
    checks++; if (bus.BUBBLE_CNT !== 16'd1) begin errors++; $display("FAIL x0_bubble_cnt: got %0d exp 1", bus.BUBBLE_CNT); end
    tick();
  endtask

  task automatic test_ex_stall();
    bus.IF_INSTR = I_ADDI; bus.IF_PC = 32'h400; bus.IMM_OUT = 32'hFFFFFFFB; bus.IF_VALID = 1'b1;
    tick();
    bus.IF_INSTR = I_SLLI; bus.IF_PC = 32'h404; bus.IMM_OUT = 32'h3; bus.EX_READY = 1'b0;
    #1;
    checks++; if (bus.ID_READY !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0h exp 0", bus.ID_READY); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.ID_EX_VALID !== 1'b1 || bus.ID_EX_PC !== 32'h400 || bus.ID_EX_IMM !== 32'hFFFFFFFB || bus.ID_READY !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got v=%0h pc=%0h imm=%0h rdy=%0h exp 1/400/fffffffb/0", i, bus.ID_EX_VALID, bus.ID_EX_PC, bus.ID_EX_IMM, bus.ID_READY);
      end
    end
    bus.EX_READY = 1'b1;
    #1;
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0h exp 1", bus.ID_READY); end
    tick();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.ID_EX_PC !== 32'h404 || bus.ID_EX_IMM !== 32'h3 || bus.ID_EX_IMM_SEL !== 3'b101) begin errors++; $display("FAIL stall_resume: got pc=%0h imm=%0h sel=%0h exp 404/3/5", bus.ID_EX_PC, bus.ID_EX_IMM, bus.ID_EX_IMM_SEL); end
    checks++; if (bus.ID_EX_RS1 !== 5'd1 || bus.ID_EX_RS2 !== 5'd0 || bus.ID_EX_RD !== 5'd1) begin errors++; $display("FAIL stall_slli_regs: got %0d/%0d/%0d exp 1/0/1", bus.ID_EX_RS1, bus.ID_EX_RS2, bus.ID_EX_RD); end
    tick();
  endtask

  task automatic test_flush();
    // flush on the hazard cycle: flush wins, no bubble
    bus.IF_INSTR = I_LW5; bus.IF_PC = 32'h500; bus.IMM_OUT = 32'h0; bus.IF_VALID = 1'b1;
    tick();
    bus.IF_INSTR = I_ADD5; bus.IF_PC = 32'h504; bus.FLUSH = 1'b1;
    #1;
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0h exp 1", bus.ID_READY); end
    tick();
    bus.FLUSH = 1'b0; bus.IF_PC = 32'h508;
    #1;
    checks++; if (bus.ID_EX_VALID !== 1'b0 || bus.FLUSH_CNT !== 16'd1 || bus.BUBBLE_CNT !== 16'd1) begin errors++; $display("FAIL flush_hz: got v=%0h fc=%0d bc=%0d exp 0/1/1", bus.ID_EX_VALID, bus.FLUSH_CNT, bus.BUBBLE_CNT); end
    tick();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.ID_EX_VALID !== 1'b1 || bus.ID_EX_PC !== 32'h508 || bus.BUBBLE_CNT !== 16'd1) begin errors++; $display("FAIL flush_run: got v=%0h pc=%0h bc=%0d exp 1/508/1", bus.ID_EX_VALID, bus.ID_EX_PC, bus.BUBBLE_CNT); end
    tick();
    // flush while in the bubble state
    bus.IF_INSTR = I_LW5; bus.IF_PC = 32'h600; bus.IF_VALID = 1'b1;
    tick();
    bus.IF_INSTR = I_ADD5; bus.IF_PC = 32'h604;
    tick();
    checks++; if (bus.BUBBLE_CNT !== 16'd2 || bus.ID_EX_VALID !== 1'b0) begin errors++; $display("FAIL flush_pre_bubble: got bc=%0d v=%0h exp 2/0", bus.BUBBLE_CNT, bus.ID_EX_VALID); end
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0; bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.FLUSH_CNT !== 16'd2 || bus.ID_EX_VALID !== 1'b0) begin errors++; $display("FAIL flush_bubble: got fc=%0d v=%0h exp 2/0", bus.FLUSH_CNT, bus.ID_EX_VALID); end
    // flush with nothing to kill is not counted
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    #1;
    checks++; if (bus.FLUSH_CNT !== 16'd2) begin errors++; $display("FAIL flush_empty: got %0d exp 2", bus.FLUSH_CNT); end
  endtask

  task automatic test_opcodes();
    logic [31:0] ops  [12];
    logic [2:0]  sels [12];
    logic [31:0] cur;
    ops[0]  = I_SLLI;        sels[0]  = 3'b101;
    ops[1]  = I_SW;          sels[1]  = 3'b010;
    ops[2]  = 32'h00208463;  sels[2]  = 3'b011; // beq
    ops[3]  = 32'h000000EF;  sels[3]  = 3'b001; // jal
    ops[4]  = 32'h123450B7;  sels[4]  = 3'b000; // lui
    ops[5]  = 32'h022081B3;  sels[5]  = 3'b111; // mul
    ops[6]  = 32'h00000097;  sels[6]  = 3'b000; // auipc
    ops[7]  = 32'h000100E7;  sels[7]  = 3'b100; // jalr
    ops[8]  = 32'hFFF13093;  sels[8]  = 3'b100; // sltiu
    ops[9]  = 32'h4020D093;  sels[9]  = 3'b101; // srai
    ops[10] = I_LW5;         sels[10] = 3'b100; // lw
    ops[11] = 32'h0000000F;  sels[11] = 3'b111; // fence
    bus.IF_VALID = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cur = ops[i];
      bus.IF_INSTR = cur;
      #1;
      checks++; if (bus.IMM_SEL !== sels[i]) begin errors++; $display("FAIL opc_sel%0d: got %0h exp %0h", i, bus.IMM_SEL, sels[i]); end
      checks++; if (bus.IMM_IN !== cur[31:7]) begin errors++; $display("FAIL opc_in%0d: got %0h exp %0h", i, bus.IMM_IN, cur[31:7]); end
    end
  endtask

  task automatic test_saturation();
    sbus.IF_INSTR = I_LWCH; sbus.IF_PC = 32'h800; sbus.IMM_OUT = 32'h0; sbus.IF_VALID = 1'b1;
    repeat (4) tick();
    checks++; if (sbus.BUBBLE_CNT !== 2'd2) begin errors++; $display("FAIL sat_mid: got %0d exp 2", sbus.BUBBLE_CNT); end
    repeat (8) tick();
    checks++; if (sbus.BUBBLE_CNT !== 2'd3) begin errors++; $display("FAIL sat_full: got %0d exp 3", sbus.BUBBLE_CNT); end
    sbus.IF_VALID = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.IF_INSTR = I_ADDI; bus.IF_PC = 32'h700; bus.IMM_OUT = 32'hFFFFFFFB; bus.IF_VALID = 1'b1;
    tick();
    bus.IF_VALID = 1'b0;
    checks++; if (bus.ID_EX_VALID !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %0h exp 1", bus.ID_EX_VALID); end
    #2;
    rst_n = 1'b0;
    bus.IF_INSTR = I_SW;
    #1;
    checks++; if (bus.ID_EX_VALID !== 1'b0 || bus.ID_EX_PC !== 32'h0 || bus.ID_EX_IMM !== 32'h0 || bus.ID_EX_IMM_SEL !== 3'b000) begin errors++; $display("FAIL ar_entry: got v=%0h pc=%0h imm=%0h sel=%0h exp 0/0/0/0", bus.ID_EX_VALID, bus.ID_EX_PC, bus.ID_EX_IMM, bus.ID_EX_IMM_SEL); end
    checks++; if (bus.ID_EX_RD !== 5'd0 || bus.ID_EX_RS1 !== 5'd0 || bus.ID_EX_RS2 !== 5'd0 || bus.ID_EX_MEMREAD !== 1'b0) begin errors++; $display("FAIL ar_regs: got %0d/%0d/%0d/%0h exp 0/0/0/0", bus.ID_EX_RD, bus.ID_EX_RS1, bus.ID_EX_RS2, bus.ID_EX_MEMREAD); end
    checks++; if (bus.BUBBLE_CNT !== 16'd0 || bus.FLUSH_CNT !== 16'd0 || sbus.BUBBLE_CNT !== 2'd0) begin errors++; $display("FAIL ar_cnt: got %0d/%0d/%0d exp 0/0/0", bus.BUBBLE_CNT, bus.FLUSH_CNT, sbus.BUBBLE_CNT); end
    checks++; if (bus.ID_READY !== 1'b1 || bus.IMM_SEL !== 3'b010) begin errors++; $display("FAIL ar_comb: got rdy=%0h sel=%0h exp 1/2", bus.ID_READY, bus.IMM_SEL); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.IF_INSTR = 32'h0;  bus.IF_PC = 32'h0;  bus.IF_VALID = 1'b0;
    bus.EX_READY = 1'b1;   bus.FLUSH = 1'b0;   bus.IMM_OUT = 32'h0;
    sbus.IF_INSTR = 32'h0; sbus.IF_PC = 32'h0; sbus.IF_VALID = 1'b0;
    sbus.EX_READY = 1'b1;  sbus.FLUSH = 1'b0;  sbus.IMM_OUT = 32'h0;
    test_reset();
    test_addi();
    test_load_use();
    test_x0_load();
    test_ex_stall();
    test_flush();
    test_opcodes();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
